conv_out_ctrl: RTL

- Output stage directly downstream of the line-buffer/MAC convolver datapath. Consumes one raw convolution sum per accepted pixel.
- Tracks the row/column position of the streamed pixel in an N x N image.
- Passes a result only when the KxK window lies fully inside the image and is aligned to the stride. Applies scaling, optional ReLU and saturation.
- Emits a registered result with a one-cycle valid strobe, plus an end-of-frame pulse.

---
 rtl/conv_out_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/conv_out_ctrl.sv
// Output stage of the convolver: tracks pixel position, gates results to stride-aligned
// in-image windows, then rescales, optionally rectifies and saturates the raw window sum.
module conv_out_ctrl #(
  parameter int N     = 4,
  parameter int K     = 3,
  parameter int S     = 1,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic signed [IN_W-1:0]  sum_in,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] conv_out,
  output logic                    valid_conv,
  output logic                    end_conv
);

  localparam int CW = $clog2(N) + 1;
  localparam int PW = $clog2(S) + 1;

  localparam logic [CW-1:0] LAST_POS = CW'(N - 1);
  localparam logic [CW-1:0] KM1      = CW'(K - 1);
  localparam logic [PW-1:0] SLAST    = PW'(S - 1);

  localparam logic signed [IN_W-1:0] SAT_MAX =
    {{(IN_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN =
    {{(IN_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [PW-1:0] colPh_q, colPh_d, rowPh_q, rowPh_d;
  logic signed [OUT_W-1:0] conv_q, conv_d;
  logic valid_q, end_q;
  logic lastCol, lastRow, winValid, frameEnd;
  logic signed [IN_W-1:0] scaled;

  // Stride phase is zero at position K-1 and cycles 0..S-1 from there on.
  function automatic logic [PW-1:0] nextPhase(input logic [CW-1:0] pos,
                                               input logic [PW-1:0] ph);
    if (pos < KM1)        return '0;
    else if (ph == SLAST) return '0;
    else                  return ph + PW'(1);
  endfunction

  always_comb begin
    lastCol  = (col_q == LAST_POS);
    lastRow  = (row_q == LAST_POS);
    frameEnd = lastCol && lastRow;
    winValid = (row_q >= KM1) && (col_q >= KM1) && (colPh_q == '0) && (rowPh_q == '0);

    col_d   = col_q + CW'(1);
    colPh_d = nextPhase(col_q, colPh_q);
    row_d   = row_q;
    rowPh_d = rowPh_q;
    if (lastCol) begin
      col_d   = '0;
      colPh_d = '0;
      if (lastRow) begin
        row_d   = '0;
        rowPh_d = '0;
      end else begin
        row_d   = row_q + CW'(1);
        rowPh_d = nextPhase(row_q, rowPh_q);
      end
    end
  end

  always_comb begin
    scaled = sum_in >>> SHIFT;
    if (relu_en && scaled[IN_W-1]) scaled = '0;
    if (scaled > SAT_MAX)      conv_d = OUT_MAX;
    else if (scaled < SAT_MIN) conv_d = OUT_MIN;
    else                       conv_d = scaled[OUT_W-1:0];
  end

  // Counters advance only on accepted pixels; strobes are rebuilt every edge so they never stretch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      colPh_q <= '0;
      rowPh_q <= '0;
      conv_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else if (ce) begin
      col_q   <= col_d;
      row_q   <= row_d;
      colPh_q <= colPh_d;
      rowPh_q <= rowPh_d;
      valid_q <= winValid;
      end_q   <= frameEnd;
      if (winValid) conv_q <= conv_d;
    end else begin
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end
  end

  assign conv_out   = conv_q;
  assign valid_conv = valid_q;
  assign end_conv   = end_q;

endmodule
